// File: rtl/gray_pkg.sv
// Shared gray/binary helpers for pointer-crossing logic. Functions work at a fixed
// maximum width; narrower pointers are zero-extended on the way in and truncated on the way out.
package gray_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_W           = 32;

  typedef logic [MAX_W-1:0] gw_t;

  // Zero-extended upper bits decode to zero, so the prefix XOR from the top stays exact.
  function automatic gw_t gray2bin(input gw_t g);
    gw_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gw_t bin2gray(input gw_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Pointer-crossing bundle: the source side drives gray_in, the synchronizer drives the rest.
// No backpressure: valid only says bin_out/step/err/delta are meaningful, there is no ready.
interface gray_ptr_sync_if #(
  parameter int width = 3
);

  logic [width-1:0] gray_in;
  logic [width-1:0] gray_sync;
  logic [width-1:0] bin_out;
  logic             valid;
  logic             step;
  logic             err;
  logic [width-1:0] delta;

  modport master (
    output gray_in,
    input  gray_sync, bin_out, valid, step, err, delta
  );

  modport slave (
    input  gray_in,
    output gray_sync, bin_out, valid, step, err, delta
  );

endinterface

// File: rtl/sync_chain.sv
// Plain width x stages flop chain for clock-domain crossing; no logic between stages
// so synthesis keeps the flops back-to-back.
module sync_chain #(
  parameter int width  = 3,
  parameter int stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] s [stages];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) begin
        s[i] <= '0;
      end
    end else begin
      s[0] <= d;
      for (int i = 1; i < stages; i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  assign q = s[stages-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Destination-side gray pointer receiver: synchronize, decode to binary, and classify each
// change as a legal single step or an illegal multi-bit jump.
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int width       = 3,
  parameter int sync_stages = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  gray_ptr_sync_if.slave                      bus,
  output logic [$clog2(sync_stages+2)-1:0]    dbg_prime_cnt
);

  localparam int cw = $clog2(sync_stages + 2);
  localparam logic [cw-1:0] prime_done = cw'(sync_stages + 1);

  generate
    if (sync_stages < MIN_SYNC_STAGES) begin : g_bad_stages
      $error("gray_ptr_sync: sync_stages must be at least 2");
    end
    if (width < 2 || width > MAX_W) begin : g_bad_width
      $error("gray_ptr_sync: width out of range");
    end
  endgenerate

  logic [width-1:0] gray_sync;
  logic [width-1:0] prev_gray;
  logic [width-1:0] bin_q;
  logic [width-1:0] delta_q;
  logic             valid_q;
  logic             step_q;
  logic             err_q;
  logic [cw-1:0]    cnt_q;

  logic [width-1:0] x;
  logic [width-1:0] new_bin;
  logic [width-1:0] old_bin;
  logic             changed;
  logic             multi;
  logic             single;

  sync_chain #(
    .width  (width),
    .stages (sync_stages)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.gray_in),
    .q   (gray_sync)
  );

  // x & (x-1) clears the lowest set bit; anything left means more than one bit flipped.
  always_comb begin
    x       = gray_sync ^ prev_gray;
    new_bin = width'(gray2bin(gw_t'(gray_sync)));
    old_bin = width'(gray2bin(gw_t'(prev_gray)));
    changed = |x;
    multi   = |(x & (x - 1'b1));
    single  = changed & ~multi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray <= '0;
      bin_q     <= '0;
      delta_q   <= '0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      prev_gray <= gray_sync;
      bin_q     <= new_bin;
      if (cnt_q != prime_done) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cnt_q == prime_done - 1'b1) begin
        valid_q <= 1'b1;
      end
      // Flags stay quiet until the chain has flushed its post-reset fill.
      step_q  <= valid_q & single;
      err_q   <= valid_q & multi;
      delta_q <= (valid_q && changed) ? (new_bin - old_bin) : '0;
    end
  end

  assign bus.gray_sync  = gray_sync;
  assign bus.bin_out    = bin_q;
  assign bus.valid      = valid_q;
  assign bus.step       = step_q;
  assign bus.err        = err_q;
  assign bus.delta      = delta_q;
  assign dbg_prime_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync at width=4, sync_stages=2; expected values hand-derived
// from the two-flop latency plus one decode register.
module tb_gray_ptr_sync;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_prime_cnt;
  int         checks;
  int         errors;

  gray_ptr_sync_if #(.width(4)) bus ();

  gray_ptr_sync #(
    .width       (4),
    .sync_stages (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .dbg_prime_cnt (dbg_prime_cnt)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] bin, input logic vld,
                         input logic stp, input logic er, input logic [3:0] dlt);
    chk({tag, ".bin_out"}, 32'(bus.bin_out), 32'(bin));
    chk({tag, ".valid"},   32'(bus.valid),   32'(vld));
    chk({tag, ".step"},    32'(bus.step),    32'(stp));
    chk({tag, ".err"},     32'(bus.err),     32'(er));
    chk({tag, ".delta"},   32'(bus.delta),   32'(dlt));
  endtask

  // Drive g and follow it through: two quiet edges, the reported edge, then a quiet edge.
  task automatic move(input string tag, input logic [3:0] g, input logic [3:0] old_bin,
                      input logic [3:0] new_bin, input logic stp, input logic er,
                      input logic [3:0] dlt);
    bus.gray_in = g;
    tick();
    chk_all({tag, "@1"}, old_bin, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all({tag, "@2"}, old_bin, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all({tag, "@3"}, new_bin, 1'b1, stp, er, dlt);
    tick();
    chk_all({tag, "@4"}, new_bin, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.gray_in = 4'b1000;

    // reset held for three edges with a nonzero pointer on the input
    tick(); tick(); tick();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("reset.gray_sync", 32'(bus.gray_sync), 32'h0);
    chk("reset.prime_cnt", 32'(dbg_prime_cnt), 32'd0);

    // priming
    rst = 1'b0;
    tick();
    chk_all("prime1", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all("prime2", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("prime2.gray_sync", 32'(bus.gray_sync), 32'h8);
    tick();
    chk_all("prime3", 4'd15, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("prime3.prime_cnt", 32'(dbg_prime_cnt), 32'd3);
    tick();
    chk_all("prime4", 4'd15, 1'b1, 1'b0, 1'b0, 4'd0);

    // wrap-around 15 -> 0
    move("wrap", 4'b0000, 4'd15, 4'd0, 1'b1, 1'b0, 4'd1);

    // back-to-back increments 0 -> 1 -> 2 -> 3
    bus.gray_in = 4'b0001;
    tick();
    chk_all("inc1", 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    bus.gray_in = 4'b0011;
    tick();
    chk_all("inc2", 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    bus.gray_in = 4'b0010;
    tick();
    chk_all("inc3", 4'd1, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("inc4", 4'd2, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("inc5", 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    chk_all("inc6", 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);

    // count-down 3 -> 2 and 2 -> 1
    move("down32", 4'b0011, 4'd3, 4'd2, 1'b1, 1'b0, 4'd15);
    move("down21", 4'b0001, 4'd2, 4'd1, 1'b1, 1'b0, 4'd15);

    // illegal two-bit jump 1 -> 5
    move("jump", 4'b0111, 4'd1, 4'd5, 1'b0, 1'b1, 4'd4);

    // mid-operation reset during an incrementing stream
    bus.gray_in = 4'b0101;
    tick();
    chk_all("mrst0", 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
    bus.gray_in = 4'b0100;
    rst = 1'b1;
    tick();
    chk_all("mrst1", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("mrst1.gray_sync", 32'(bus.gray_sync), 32'h0);
    chk("mrst1.prime_cnt", 32'(dbg_prime_cnt), 32'd0);
    rst = 1'b0;
    bus.gray_in = 4'b1100;
    tick();
    chk_all("mrst2", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all("mrst3", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("mrst3.gray_sync", 32'(bus.gray_sync), 32'hc);
    tick();
    chk_all("mrst4", 4'd8, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all("mrst5", 4'd8, 1'b1, 1'b0, 1'b0, 4'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
